// File: rtl/oam_dma_initiator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oam_dma_initiator_if : 8-bit DataBus seen from an initiator (master) port  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface oam_dma_initiator_if #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 8
);
    logic                 req;
    logic                 gnt;
    logic [ADDR_SIZE-1:0] addr;
    logic [DATA_SIZE-1:0] wdata;
    logic                 rd;
    logic                 wr;
    logic [DATA_SIZE-1:0] rdata;
    logic                 rvalid;

    modport master (
        output req, addr, wdata, rd, wr,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, addr, wdata, rd, wr,
        output gnt, rdata, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oam_dma_initiator : OAM DMA bus master, read/write byte copy to DST_BASE   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module oam_dma_initiator #(
    parameter int                   ADDR_SIZE = 16,
    parameter int                   DATA_SIZE = 8,
    parameter logic [ADDR_SIZE-1:0] TRIG_ADDR = 16'hFF46,
    parameter logic [ADDR_SIZE-1:0] DST_BASE  = 16'hFE00,
    parameter int                   LENGTH    = 160,
    parameter logic [DATA_SIZE-1:0] OPEN_BUS  = 8'hFF
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 cfg_wr,
    input  wire logic [ADDR_SIZE-1:0] cfg_addr,
    input  wire logic [DATA_SIZE-1:0] cfg_wdata,
    output logic      [DATA_SIZE-1:0] cfg_rdata,
    output logic                      busy,
    output logic                      done,
    oam_dma_initiator_if.master       bus
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] src;
    logic [7:0]           idx;

    logic                 trigger;
    logic [7:0]           idx_nxt;
    logic [ADDR_SIZE-1:0] src_base;
    logic [ADDR_SIZE-1:0] rd_addr_cur;
    logic [ADDR_SIZE-1:0] rd_addr_nxt;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [DATA_SIZE-1:0] rd_byte;

    assign trigger     = cfg_wr && (cfg_addr == TRIG_ADDR);
    assign idx_nxt     = idx + 8'd1;
    assign src_base    = ADDR_SIZE'({src, 8'h00});
    assign rd_addr_cur = src_base + ADDR_SIZE'(idx);
    assign rd_addr_nxt = src_base + ADDR_SIZE'(idx_nxt);
    assign wr_addr     = DST_BASE + ADDR_SIZE'(idx);
    // An unclaimed read floats the bus; substitute the open-bus value.
    assign rd_byte     = bus.rvalid ? bus.rdata : OPEN_BUS;

    // Outputs are registered alongside the state so each strobe lines up
    // exactly with the cycle its state occupies.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            src       <= '0;
            cfg_rdata <= '0;
            bus.req   <= 1'b0;
            bus.rd    <= 1'b0;
            bus.wr    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bus.rd    <= 1'b0;
            bus.wr    <= 1'b0;
            bus.addr  <= '0;
            bus.wdata <= '0;
            done      <= 1'b0;

            if (trigger) begin
                src       <= cfg_wdata;
                cfg_rdata <= cfg_wdata;
                idx       <= '0;
                state     <= S_REQ;
                bus.req   <= 1'b1;
                busy      <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        bus.req <= 1'b0;
                        busy    <= 1'b0;
                    end
                    S_REQ: begin
                        if (bus.gnt) begin
                            state    <= S_RD;
                            bus.rd   <= 1'b1;
                            bus.addr <= rd_addr_cur;
                        end
                    end
                    S_RD: begin
                        state <= S_CAP;
                    end
                    S_CAP: begin
                        state     <= S_WR;
                        bus.wr    <= 1'b1;
                        bus.addr  <= wr_addr;
                        bus.wdata <= rd_byte;
                    end
                    S_WR: begin
                        if (idx == LAST_IDX) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            bus.req <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            idx <= idx_nxt;
                            // Grant is re-checked only here, between byte pairs.
                            if (bus.gnt) begin
                                state    <= S_RD;
                                bus.rd   <= 1'b1;
                                bus.addr <= rd_addr_nxt;
                            end else begin
                                state <= S_REQ;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state   <= S_IDLE;
                        bus.req <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_oam_dma_initiator : directed bench with bus slave model and scoreboard  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_oam_dma_initiator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_wr;
    logic [15:0] cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        busy;
    logic        done;

    oam_dma_initiator_if #(.ADDR_SIZE(16), .DATA_SIZE(8)) bus ();

    oam_dma_initiator dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int trig_cyc = 0;
    int done_cnt = 0;
    int viol = 0;
    logic [15:0] rd_log[$];
    logic [23:0] wr_log[$];

    // Memory decoded at C000..DFFF with an address-derived pattern.
    function automatic logic claimed(input logic [15:0] a);
        return (a >= 16'hC000) && (a <= 16'hDFFF);
    endfunction

    function automatic logic [7:0] pattern(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] s, input int i);
        logic [15:0] a;
        a = 16'({s, 8'h00} + i);
        return claimed(a) ? pattern(a) : 8'hFF;
    endfunction

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        bus.rvalid <= 1'b0;
        bus.rdata  <= 8'h00;
        if (bus.rd) begin
            bus.rdata  <= pattern(bus.addr);
            bus.rvalid <= claimed(bus.addr);
            rd_log.push_back(bus.addr);
        end
        if (bus.wr)
            wr_log.push_back({bus.addr, bus.wdata});
        if (done)
            done_cnt <= done_cnt + 1;
        if ((bus.rd && bus.wr) ||
            (!bus.rd && !bus.wr && (bus.addr != 16'h0 || bus.wdata != 8'h0)) ||
            ((bus.rd || bus.wr) && !bus.req))
            viol <= viol + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
    endtask

    task automatic cfg_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_wr    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        trig_cyc  = cyc;
        @(negedge clk);
        cfg_wr    = 1'b0;
        cfg_addr  = 16'h0;
        cfg_wdata = 8'h0;
    endtask

    task automatic wait_done(input int budget, output int dcyc);
        dcyc = -1;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                dcyc = cyc - trig_cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_strobe(input logic is_wr, input logic [15:0] a, input int budget,
                               output logic ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if ((is_wr ? bus.wr : bus.rd) && bus.addr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_logs(input string tag, input logic [7:0] s, input int n);
        int rd_bad = 0;
        int wr_bad = 0;
        logic [23:0] e;
        chk({tag, " rd count"}, rd_log.size(), n);
        chk({tag, " wr count"}, wr_log.size(), n);
        for (int i = 0; i < n && i < rd_log.size(); i++)
            if (rd_log[i] !== 16'({s, 8'h00} + i)) rd_bad++;
        for (int i = 0; i < n && i < wr_log.size(); i++) begin
            e = {16'(16'hFE00 + i), exp_byte(s, i)};
            if (wr_log[i] !== e) wr_bad++;
        end
        chk({tag, " rd addr errors"}, rd_bad, 0);
        chk({tag, " wr addr/data errors"}, wr_bad, 0);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        bit          starts;
        logic [7:0]  exp_cfg;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   dc;
        int   d0;
        int   stall_bad;
        int   wcnt;
        logic ok;

        vecs[0] = '{16'hFF46, 8'hC0, 1'b1, 8'hC0};
        vecs[1] = '{16'hFF46, 8'h51, 1'b1, 8'h51};
        vecs[2] = '{16'hFF47, 8'h33, 1'b0, 8'h51};
        vecs[3] = '{16'hFF45, 8'hC0, 1'b0, 8'h51};
        vecs[4] = '{16'hFF46, 8'hDF, 1'b1, 8'hDF};
        vecs[5] = '{16'hFF46, 8'hFF, 1'b1, 8'hFF};

        reset_n   = 1'b0;
        cfg_wr    = 1'b0;
        cfg_addr  = 16'h0;
        cfg_wdata = 8'h0;
        bus.gnt   = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset bus_req", bus.req, 0);
        chk("reset busy/done", {busy, done}, 0);
        chk("reset strobes", {bus.rd, bus.wr}, 0);
        chk("reset bus_addr", bus.addr, 0);
        chk("reset cfg_rdata", cfg_rdata, 0);
        reset_n = 1'b1;

        foreach (vecs[v]) begin
            clear_logs();
            d0 = done_cnt;
            cfg_write(vecs[v].addr, vecs[v].data);
            if (vecs[v].starts) begin
                chk($sformatf("vec%0d busy", v), busy, 1);
                wait_done(700, dc);
                chk($sformatf("vec%0d done cycle", v), dc, 482);
                @(negedge clk);
                chk($sformatf("vec%0d busy after", v), busy, 0);
                check_logs($sformatf("vec%0d", v), vecs[v].data, 160);
                chk($sformatf("vec%0d done pulses", v), done_cnt - d0, 1);
            end else begin
                repeat (5) @(negedge clk);
                chk($sformatf("vec%0d busy", v), busy, 0);
                chk($sformatf("vec%0d strobes", v), rd_log.size() + wr_log.size(), 0);
            end
            chk($sformatf("vec%0d cfg_rdata", v), cfg_rdata, vecs[v].exp_cfg);
        end

        // Grant withdrawn across the byte-50 write for ten sampling edges.
        clear_logs();
        cfg_write(16'hFF46, 8'hC0);
        wait_strobe(1'b1, 16'hFE32, 300, ok);
        chk("stall reach idx50 wr", ok, 1);
        bus.gnt   = 1'b0;
        stall_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.rd || bus.wr || !bus.req || !busy) stall_bad++;
        end
        bus.gnt = 1'b1;
        chk("stall quiet bus", stall_bad, 0);
        @(negedge clk);
        chk("stall resume rd", bus.rd, 1);
        chk("stall resume addr", bus.addr, 16'hC033);
        wait_done(700, dc);
        chk("stall done cycle", dc, 492);
        check_logs("stall", 8'hC0, 160);

        // Retrigger to D0 while the byte-20 write is on the bus.
        d0 = done_cnt;
        cfg_write(16'hFF46, 8'hC0);
        wait_strobe(1'b1, 16'hFE14, 300, ok);
        chk("retrig reach idx20 wr", ok, 1);
        cfg_wr    = 1'b1;
        cfg_addr  = 16'hFF46;
        cfg_wdata = 8'hD0;
        trig_cyc  = cyc;
        @(posedge clk);
        #1;
        clear_logs();
        @(negedge clk);
        cfg_wr    = 1'b0;
        cfg_addr  = 16'h0;
        cfg_wdata = 8'h0;
        @(negedge clk);
        chk("retrig first rd addr", bus.addr, 16'hD000);
        wait_done(700, dc);
        chk("retrig done cycle", dc, 482);
        check_logs("retrig", 8'hD0, 160);
        chk("retrig done pulses", done_cnt - d0, 1);
        chk("retrig cfg_rdata", cfg_rdata, 8'hD0);

        // Reset while the byte-80 read is on the bus.
        cfg_write(16'hFF46, 8'hC0);
        wait_strobe(1'b0, 16'hC050, 400, ok);
        chk("rst reach idx80 rd", ok, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("rst req/busy/done", {bus.req, busy, done}, 0);
        chk("rst strobes", {bus.rd, bus.wr}, 0);
        chk("rst addr/wdata", {bus.addr, bus.wdata}, 0);
        chk("rst cfg_rdata", cfg_rdata, 0);
        wcnt = wr_log.size();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst no further writes", wr_log.size(), wcnt);
        chk("rst busy stays low", busy, 0);

        chk("bus protocol violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
